multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states, mux/ALU select codes.
// Pure declarations; no logic or timing of its own.
package mips_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // States that stall on mem_ready and therefore run the timeout counter.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM; datapath controls decode combinationally from state and mem_ready (0 latency).
// Backpressure: mem_ready stalls FETCH/MEMRD/MEMWR; a stall reaching TO_CYCLES enters a sticky FAULT.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TO_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       fault
);

  localparam logic [4:0] WAIT_LIMIT = 5'(TO_CYCLES - 1);

  state_t     cur_state;
  state_t     next_state;
  logic [4:0] wait_cnt;
  logic       wait_expired;
  logic       fetch_rdy;
  ctrl_t      ctrl;

  assign wait_expired = (wait_cnt == WAIT_LIMIT);

  // Fetch write gating is also held off by reset so no PC/IR write escapes while rst_n is low.
  assign fetch_rdy = mem_ready & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  // Counter restarts on every state change, so each wait state is entered with a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 5'd0;
    end else if (next_state != cur_state) begin
      wait_cnt <= 5'd0;
    end else if (is_wait_state(cur_state) && !mem_ready) begin
      wait_cnt <= wait_cnt + 5'd1;
    end
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_FETCH: begin
        if (mem_ready)         next_state = S_DECODE;
        else if (wait_expired) next_state = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      next_state = S_MEMRD;
        else if (opcode == OP_SW) next_state = S_MEMWR;
        else                      next_state = S_FAULT;
      end
      S_MEMRD: begin
        if (mem_ready)         next_state = S_MEMWB;
        else if (wait_expired) next_state = S_FAULT;
      end
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)         next_state = S_FETCH;
        else if (wait_expired) next_state = S_FAULT;
      end
      S_EXEC:   next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_ADDIEX: next_state = S_ADDIWB;
      S_ADDIWB: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_FAULT;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (cur_state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = fetch_rdy;
        ctrl.pc_write  = fetch_rdy;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign instr_done  = ctrl.instr_done;
  assign state       = cur_state;
  assign fault       = (cur_state == S_FAULT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: default instance plus a TO_CYCLES=4 instance for timeout cases.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, alu_src_a, reg_write, reg_dst, instr_done, fault;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic [3:0] state;

  logic       t4_pc_write, t4_pc_write_cond, t4_i_or_d, t4_mem_read, t4_mem_write, t4_ir_write;
  logic       t4_mem_to_reg, t4_alu_src_a, t4_reg_write, t4_reg_dst, t4_instr_done, t4_fault;
  logic [1:0] t4_alu_op, t4_alu_src_b, t4_pc_source;
  logic [3:0] t4_state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .IorD(i_or_d), .MemRead(mem_read),
    .MemWrite(mem_write), .IRWrite(ir_write), .MemtoReg(mem_to_reg), .ALUSrcA(alu_src_a),
    .RegWrite(reg_write), .RegDst(reg_dst), .ALUOp(alu_op), .ALUSrcB(alu_src_b),
    .PCSource(pc_source), .state(state), .instr_done(instr_done), .fault(fault)
  );

  multicycle_ctrl #(.TO_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(t4_pc_write), .PCWriteCond(t4_pc_write_cond), .IorD(t4_i_or_d), .MemRead(t4_mem_read),
    .MemWrite(t4_mem_write), .IRWrite(t4_ir_write), .MemtoReg(t4_mem_to_reg), .ALUSrcA(t4_alu_src_a),
    .RegWrite(t4_reg_write), .RegDst(t4_reg_dst), .ALUOp(t4_alu_op), .ALUSrcB(t4_alu_src_b),
    .PCSource(t4_pc_source), .state(t4_state), .instr_done(t4_instr_done), .fault(t4_fault)
  );

  // Inputs change at negedge+2; outputs are checked at negedge+3, well clear of posedge.
  task automatic next_cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = OP_LW; mem_ready = 1'b1;
    #3;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if ({fault, instr_done} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {fault, instr_done}); end
    n_cmp++; if ({pc_write, ir_write, reg_write, mem_write} !== 4'b0000) begin n_err++; $display("FAIL reset_writes: got %b want 0000", {pc_write, ir_write, reg_write, mem_write}); end
    @(posedge clk); #1;
    n_cmp++; if (t4_state !== 4'd0 || state !== 4'd0) begin n_err++; $display("FAIL reset_hold: got %0d/%0d want 0/0", state, t4_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [5];
    int done_cnt;
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    done_cnt = 0;
    do_reset();
    opcode = OP_LW; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cyc();
      #1;
      n_cmp++; if (state !== exp_st[i]) begin n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      if (instr_done) done_cnt++;
      if (i == 0) begin
        n_cmp++; if ({mem_read, ir_write, pc_write, alu_src_b} !== 5'b11101) begin n_err++; $display("FAIL lw_fetch_ctl: got %b want 11101", {mem_read, ir_write, pc_write, alu_src_b}); end
      end
      if (i == 3) begin
        n_cmp++; if ({mem_read, i_or_d, reg_write} !== 3'b110) begin n_err++; $display("FAIL lw_memrd_ctl: got %b want 110", {mem_read, i_or_d, reg_write}); end
      end
    end
    n_cmp++; if ({mem_to_reg, reg_write, reg_dst, instr_done} !== 4'b1101) begin n_err++; $display("FAIL lw_memwb_ctl: got %b want 1101", {mem_to_reg, reg_write, reg_dst, instr_done}); end
    next_cyc(); #1;
    if (instr_done) done_cnt++;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL lw_return: got %0d want 0", state); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL lw_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_st [8];
    int done_cnt;
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd11, 4'd0};
    done_cnt = 0;
    do_reset();
    opcode = OP_RTYPE; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cyc();
      if (i == 4) opcode = OP_J;
      #1;
      n_cmp++; if (state !== exp_st[i]) begin n_err++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      if (instr_done) done_cnt++;
      if (i == 2) begin
        n_cmp++; if ({alu_src_a, alu_op, alu_src_b} !== 5'b11000) begin n_err++; $display("FAIL b2b_exec_ctl: got %b want 11000", {alu_src_a, alu_op, alu_src_b}); end
      end
      if (i == 3) begin
        n_cmp++; if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin n_err++; $display("FAIL b2b_aluwb_ctl: got %b want 110", {reg_write, reg_dst, mem_to_reg}); end
      end
      if (i == 6) begin
        n_cmp++; if ({pc_write, pc_source, reg_write} !== 4'b1100) begin n_err++; $display("FAIL b2b_jump_ctl: got %b want 1100", {pc_write, pc_source, reg_write}); end
      end
    end
    n_cmp++; if (done_cnt !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
  endtask

  task automatic test_sw_wait();
    logic [3:0] exp_st [8];
    logic       rdy [8];
    int         wr_cnt;
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    rdy    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wr_cnt = 0;
    do_reset();
    opcode = OP_SW;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cyc();
      mem_ready = rdy[i];
      #1;
      n_cmp++; if (state !== exp_st[i]) begin n_err++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      if (mem_write) wr_cnt++;
      if (exp_st[i] == 4'd5) begin
        n_cmp++; if ({mem_write, i_or_d, instr_done} !== {2'b11, rdy[i]}) begin n_err++; $display("FAIL sw_memwr_ctl[%0d]: got %b want %b", i, {mem_write, i_or_d, instr_done}, {2'b11, rdy[i]}); end
      end
    end
    n_cmp++; if (wr_cnt !== 4) begin n_err++; $display("FAIL sw_write_cycles: got %0d want 4", wr_cnt); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL sw_no_fault: got %b want 0", fault); end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    opcode = OP_LW; mem_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cyc();
      if (i == 5) mem_ready = 1'b1;
      #1;
      n_cmp++; if (t4_state !== ((i < 4) ? 4'd0 : 4'd12)) begin n_err++; $display("FAIL to_state[%0d]: got %0d want %0d", i, t4_state, (i < 4) ? 0 : 12); end
      n_cmp++; if (t4_fault !== (i >= 4)) begin n_err++; $display("FAIL to_fault[%0d]: got %b want %b", i, t4_fault, (i >= 4)); end
    end
    n_cmp++; if ({t4_pc_write, t4_mem_read, t4_ir_write, t4_reg_write, t4_mem_write, t4_instr_done, t4_alu_src_b} !== 8'd0) begin
      n_err++; $display("FAIL to_fault_outputs: got %b want 0", {t4_pc_write, t4_mem_read, t4_ir_write, t4_reg_write, t4_mem_write, t4_instr_done, t4_alu_src_b});
    end
    n_cmp++; if (state !== 4'd1) begin n_err++; $display("FAIL to_default_inst: got %0d want 1", state); end
    do_reset();
    #1;
    n_cmp++; if ({t4_state, t4_fault} !== 5'b00000) begin n_err++; $display("FAIL to_cleared: got %b want 00000", {t4_state, t4_fault}); end
  endtask

  task automatic test_ready_wins();
    do_reset();
    opcode = OP_J; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cyc();
      if (i == 3) mem_ready = 1'b1;
      #1;
      n_cmp++; if (t4_state !== 4'd0) begin n_err++; $display("FAIL rw_state[%0d]: got %0d want 0", i, t4_state); end
    end
    n_cmp++; if ({t4_pc_write, t4_ir_write} !== 2'b11) begin n_err++; $display("FAIL rw_gating: got %b want 11", {t4_pc_write, t4_ir_write}); end
    next_cyc(); #1;
    n_cmp++; if ({t4_state, t4_fault} !== 5'b00010) begin n_err++; $display("FAIL rw_advance: got %b want 00010", {t4_state, t4_fault}); end
  endtask

  task automatic test_illegal_opcode();
    logic [5:0] bad_op;
    bad_op = 6'b111111;
    do_reset();
    opcode = bad_op; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cyc();
      #1;
      n_cmp++; if (state !== ((i < 2) ? 4'(i) : 4'd12)) begin n_err++; $display("FAIL ill_state[%0d]: got %0d want %0d", i, state, (i < 2) ? i : 12); end
    end
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL ill_fault: got %b want 1", fault); end
    n_cmp++; if ({pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a,
                  reg_write, reg_dst, alu_op, alu_src_b, pc_source, instr_done} !== 17'd0) begin
      n_err++; $display("FAIL ill_outputs: got %b want 0", {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                         mem_to_reg, alu_src_a, reg_write, reg_dst, alu_op, alu_src_b, pc_source, instr_done});
    end
  endtask

  task automatic test_memrd_timeout();
    do_reset();
    opcode = OP_LW;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) next_cyc();
      mem_ready = (i < 3);
      #1;
      n_cmp++; if (state !== ((i < 3) ? 4'(i) : ((i < 19) ? 4'd3 : 4'd12))) begin
        n_err++; $display("FAIL rdto_state[%0d]: got %0d want %0d", i, state, (i < 3) ? i : ((i < 19) ? 3 : 12));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = OP_LW; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cyc();
    end
    next_cyc();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if ({state, mem_read, i_or_d} !== 6'b001111) begin n_err++; $display("FAIL mid_memrd: got %b want 001111", {state, mem_read, i_or_d}); end
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL mid_async_state: got %0d want 0", state); end
    n_cmp++; if ({reg_write, mem_write, pc_write, ir_write, pc_write_cond, fault, instr_done} !== 7'd0) begin
      n_err++; $display("FAIL mid_writes: got %b want 0", {reg_write, mem_write, pc_write, ir_write, pc_write_cond, fault, instr_done});
    end
    @(posedge clk); #1;
    n_cmp++; if ({state, pc_write} !== 5'b00000) begin n_err++; $display("FAIL mid_hold: got %b want 00000", {state, pc_write}); end
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    n_cmp++; if ({state, pc_write, ir_write} !== 6'b000011) begin n_err++; $display("FAIL mid_release: got %b want 000011", {state, pc_write, ir_write}); end
    next_cyc(); #1;
    n_cmp++; if (state !== 4'd1) begin n_err++; $display("FAIL mid_restart: got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_sw_wait();
    test_fetch_timeout();
    test_ready_wins();
    test_illegal_opcode();
    test_memrd_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
